sl_receiver_sync: RTL
=====================

Name: sl_receiver_sync

Overview:
Clocked, parametrised successor to the asynchronous two-wire SL receiver. It decodes the sl0/sl1 return-to-high serial protocol. Each word is a burst of bits: an sl0 low pulse is a 0, an sl1 low pulse is a 1. Both lines low together is the stop. The block checks word length and odd parity, then buffers decoded words in a first-word-fall-through FIFO with a valid/ready handshake towards the SL-to-APB bridge core.

Parameters:
DATA_W, 32, data output width; must be >= 32.
FIFO_DEPTH, 4, number of buffered words; power of 2, >= 2.
MIN_LOW, 2, minimum consecutive synchronised low samples for a pulse to count.
TIMEOUT, 1024, idle clk cycles inside an unfinished word before it is aborted.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
sl0  in  1  serial line 0 (async, idle high)
sl1  in  1  serial line 1 (async, idle high)
mode  in  2  word length: 00=8, 01=16, 10=24, 11=32 data bits
data  out  DATA_W  received word, right-aligned, zero-extended
parity_err  out  1  sideband with data: parity check failed
len_err  out  1  sideband with data: bit count != N+1
valid  out  1  FIFO head valid
ready  in  1  consumer accepts head when valid&&ready
overflow  out  1  sticky: a completed word was dropped because the FIFO was full
clr_ovf  in  1  clears overflow
timeout_err  out  1  one-cycle pulse: word aborted by timeout
busy  out  1  word in progress (bit count > 0 or stop in progress)

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (reset).
- sl0/sl1 pass through a 2-FF synchroniser each; all decoding uses the synchronised values s0/s1.
- Reset: every output is 0; FIFO empty; FSM in IDLE; bit count 0; shift register 0; synchroniser flops set to 1.
- Low-sample counter: saturating, counts cycles with a line low; MIN_LOW qualifies pulses.
- FSM states:
  - IDLE: s0=s1=1. s0=0,s1=1 -> LOW0. s1=0,s0=1 -> LOW1. Both 0 -> STOP.
  - LOW0/LOW1: the other line also falls -> STOP; no bit is taken. Pulsed line returns high with low count >= MIN_LOW -> shift in 0 (LOW0) or 1 (LOW1), increment bit count, go IDLE. Count < MIN_LOW -> glitch: ignore, go IDLE.
  - STOP: wait for s0=s1=1. Then, if bit count > 0, push a word; clear bit count; go IDLE. A stop with bit count 0 pushes nothing.
- Word format:
  - mode is latched on the first bit of a word; later mode changes apply to the next word.
  - N data bits follow, MSB first, then 1 parity bit.
  - Odd parity: the ones count over data+parity must be odd, else parity_err=1.
  - len_err=1 if the bit count at stop != N+1.
  - Bits beyond N+1 are not shifted in (len_err stays set). On a short word, data holds the bits received, right-aligned.
  - The parity check uses the last received bit as parity.
- Push: the word is written on the cycle STOP exits. valid rises the next cycle when the FIFO was empty. Pin stop-release to valid = 4 clk.
- FIFO:
  - Head data and flags are stable while valid && !ready.
  - Pop on valid&&ready.
  - Full: push with simultaneous pop is accepted; push without pop drops the word and sets overflow.
  - Empty: valid=0 and data holds its last value.
- overflow: cleared by clr_ovf or reset. Set wins over clear in the same cycle.
- Timeout: in IDLE with bit count > 0 and both lines high for TIMEOUT consecutive cycles -> discard the word, clear bit count, pulse timeout_err for 1 cycle.
- busy = (bit count != 0) || state == STOP.
- Reset mid-word or mid-handshake: the partial word and FIFO contents are lost. No push occurs.

Test Plan:
1. Normal 16-bit word: mode=01; pulse pattern 0xA5C3 MSB first, parity bit 1, then stop (sl0 falls 2 cycles before sl1) -> data=0x0000A5C3, parity_err=0, len_err=0, valid 4 clk after stop release.
2. Parity error: same word with parity bit 0 -> data=0x0000A5C3, parity_err=1.
3. Length error: mode=00, 10 bits then stop -> len_err=1. Then 8-bit 0x3C with parity 1 -> data=0x3C, no errors.
4. Backpressure and overflow: ready=0; send FIFO_DEPTH+1 words 0x01..0x05 (mode=00) -> overflow=1, 4 words held. Raise ready -> 0x01..0x04 pop in order. clr_ovf -> overflow=0.
5. Glitch and timeout: 1-cycle sl0 low pulse -> no bit counted, busy=0. 3 bits then idle for TIMEOUT cycles -> timeout_err pulse, no push, busy=0.
6. Reset mid-word: assert reset after 7 bits of a mode=01 word -> all outputs 0. The next full word decodes correctly.

Source files
------------

// File: rtl/sl_receiver_sync.sv
`default_nettype none
// ============================================================================
// Module      : sl_receiver_sync
// Description : Clocked two-wire SL receiver. Decodes sl0/sl1 return-to-high
//               pulses (sl0 low = 0, sl1 low = 1, both low = stop), checks
//               word length and odd parity, and buffers words in a
//               first-word-fall-through FIFO with a valid/ready handshake.
// Ports       : clk, reset       - clock, synchronous active-high reset
//               sl0, sl1         - asynchronous serial lines, idle high
//               mode[1:0]        - word length 8/16/24/32 data bits
//               data, parity_err, len_err, valid, ready - FIFO head handshake
//               overflow, clr_ovf - sticky drop flag and its clear
//               timeout_err      - one-cycle pulse when a word is aborted
//               busy             - a word is in progress
// Revision    : 1.0 - initial release
// ============================================================================
module sl_receiver_sync #(
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 4,
    parameter int MIN_LOW    = 2,
    parameter int TIMEOUT    = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sl0,
    input  logic              sl1,
    input  logic [1:0]        mode,
    output logic [DATA_W-1:0] data,
    output logic              parity_err,
    output logic              len_err,
    output logic              valid,
    input  logic              ready,
    output logic              overflow,
    input  logic              clr_ovf,
    output logic              timeout_err,
    output logic              busy
);

    localparam int c_AW = $clog2(FIFO_DEPTH);
    localparam int c_LW = $clog2(MIN_LOW + 1);
    localparam int c_TW = $clog2(TIMEOUT + 1);
    localparam int c_EW = DATA_W + 2;   // stored entry: {data, parity_err, len_err}

    localparam logic [c_LW-1:0] c_MIN_LOW = c_LW'(MIN_LOW);
    localparam logic [c_TW-1:0] c_T_LAST  = c_TW'(TIMEOUT - 1);
    localparam logic [c_AW:0]   c_FULL    = (c_AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOW0 = 2'd1,
        ST_LOW1 = 2'd2,
        ST_STOP = 2'd3
    } state_t;

    // Synchronisers (idle-high, so they reset to 1)
    logic r_s0_meta_q, r_s0_q, r_s1_meta_q, r_s1_q;

    // Decoder state
    state_t            r_state_q, w_state_d;
    logic [c_LW-1:0]   r_low_q,   w_low_d;
    logic [5:0]        r_bits_q,  w_bits_d;
    logic [32:0]       r_sr_q,    w_sr_d;
    logic [1:0]        r_mode_q,  w_mode_d;
    logic [c_TW-1:0]   r_idle_q,  w_idle_d;
    logic              r_push_q,  w_push_d;
    logic [31:0]       r_wdata_q, w_wdata_d;
    logic              r_wperr_q, w_wperr_d;
    logic              r_wlerr_q, w_wlerr_d;
    logic              r_tout_q,  w_tout_d;

    logic              w_take;
    logic              w_bit;
    logic [5:0]        w_need_take;
    logic [5:0]        w_need_stop;

    // Expected bit count (N data + 1 parity) = (mode+1)*8 + 1. The first bit
    // of a word uses the live mode since that is the cycle mode is latched.
    assign w_need_take = {({1'b0, ((r_bits_q == 6'd0) ? mode : r_mode_q)} + 3'd1), 3'b001};
    assign w_need_stop = {({1'b0, r_mode_q} + 3'd1), 3'b001};

    always_comb begin
        w_state_d = r_state_q;
        w_low_d   = r_low_q;
        w_bits_d  = r_bits_q;
        w_sr_d    = r_sr_q;
        w_mode_d  = r_mode_q;
        w_idle_d  = '0;
        w_push_d  = 1'b0;
        w_wdata_d = r_wdata_q;
        w_wperr_d = r_wperr_q;
        w_wlerr_d = r_wlerr_q;
        w_tout_d  = 1'b0;
        w_take    = 1'b0;
        w_bit     = 1'b0;

        case (r_state_q)
            ST_IDLE: begin
                if (!r_s0_q && !r_s1_q) begin
                    w_state_d = ST_STOP;
                end else if (!r_s0_q) begin
                    w_state_d = ST_LOW0;
                    w_low_d   = c_LW'(1);
                end else if (!r_s1_q) begin
                    w_state_d = ST_LOW1;
                    w_low_d   = c_LW'(1);
                end else if (r_bits_q != 6'd0) begin
                    // Lines idle inside an unfinished word
                    if (r_idle_q == c_T_LAST) begin
                        w_bits_d = 6'd0;
                        w_sr_d   = '0;
                        w_tout_d = 1'b1;
                    end else begin
                        w_idle_d = r_idle_q + 1'b1;
                    end
                end
            end
            ST_LOW0, ST_LOW1: begin
                if ((r_state_q == ST_LOW0) ? !r_s1_q : !r_s0_q) begin
                    w_state_d = ST_STOP;
                end else if ((r_state_q == ST_LOW0) ? !r_s0_q : !r_s1_q) begin
                    if (r_low_q != '1)
                        w_low_d = r_low_q + 1'b1;
                end else begin
                    // Pulse ended: short pulses are glitches and are dropped
                    w_take    = (r_low_q >= c_MIN_LOW);
                    w_bit     = (r_state_q == ST_LOW1);
                    w_state_d = ST_IDLE;
                end
            end
            ST_STOP: begin
                if (r_s0_q && r_s1_q) begin
                    w_push_d  = (r_bits_q != 6'd0);
                    w_wlerr_d = (r_bits_q != w_need_stop);
                    // Shift register holds data+parity, so parity is over it all
                    w_wperr_d = ~(^r_sr_q);
                    // Last received bit is parity; short words keep every bit
                    w_wdata_d = (r_bits_q >= w_need_stop) ? r_sr_q[32:1] : r_sr_q[31:0];
                    w_bits_d  = 6'd0;
                    w_sr_d    = '0;
                    w_state_d = ST_IDLE;
                end
            end
            default: w_state_d = ST_IDLE;
        endcase

        if (w_take) begin
            if (r_bits_q == 6'd0)
                w_mode_d = mode;
            // Bits beyond N+1 are counted (for len_err) but not stored
            if (r_bits_q < w_need_take)
                w_sr_d = {r_sr_q[31:0], w_bit};
            if (r_bits_q != '1)
                w_bits_d = r_bits_q + 6'd1;
        end
    end

    // FIFO
    logic [c_EW-1:0] r_mem_q [FIFO_DEPTH];
    logic [c_AW-1:0] r_wr_q, r_rd_q;
    logic [c_AW:0]   r_cnt_q;
    logic [c_EW-1:0] r_last_q;
    logic            r_ovf_q;
    logic            w_full;
    logic            w_pop;
    logic            w_wr;
    logic [c_EW-1:0] w_head;
    logic [c_EW-1:0] w_out;

    assign w_full = (r_cnt_q == c_FULL);
    assign w_pop  = valid && ready;
    assign w_wr   = r_push_q && (!w_full || w_pop);
    assign w_head = r_mem_q[r_rd_q];
    // With the FIFO empty the last popped entry is presented
    assign w_out  = valid ? w_head : r_last_q;

    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem_q[r_wr_q] <= {DATA_W'(r_wdata_q), r_wperr_q, r_wlerr_q};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s0_meta_q <= 1'b1;
            r_s0_q      <= 1'b1;
            r_s1_meta_q <= 1'b1;
            r_s1_q      <= 1'b1;
            r_state_q   <= ST_IDLE;
            r_low_q     <= '0;
            r_bits_q    <= '0;
            r_sr_q      <= '0;
            r_mode_q    <= '0;
            r_idle_q    <= '0;
            r_push_q    <= 1'b0;
            r_wdata_q   <= '0;
            r_wperr_q   <= 1'b0;
            r_wlerr_q   <= 1'b0;
            r_tout_q    <= 1'b0;
            r_wr_q      <= '0;
            r_rd_q      <= '0;
            r_cnt_q     <= '0;
            r_last_q    <= '0;
            r_ovf_q     <= 1'b0;
        end else begin
            r_s0_meta_q <= sl0;
            r_s0_q      <= r_s0_meta_q;
            r_s1_meta_q <= sl1;
            r_s1_q      <= r_s1_meta_q;
            r_state_q   <= w_state_d;
            r_low_q     <= w_low_d;
            r_bits_q    <= w_bits_d;
            r_sr_q      <= w_sr_d;
            r_mode_q    <= w_mode_d;
            r_idle_q    <= w_idle_d;
            r_push_q    <= w_push_d;
            r_wdata_q   <= w_wdata_d;
            r_wperr_q   <= w_wperr_d;
            r_wlerr_q   <= w_wlerr_d;
            r_tout_q    <= w_tout_d;
            if (w_wr)
                r_wr_q <= r_wr_q + 1'b1;
            if (w_pop) begin
                r_rd_q   <= r_rd_q + 1'b1;
                r_last_q <= w_head;
            end
            r_cnt_q <= r_cnt_q + (c_AW + 1)'(w_wr) - (c_AW + 1)'(w_pop);
            // Set has priority over clear
            if (r_push_q && w_full && !w_pop)
                r_ovf_q <= 1'b1;
            else if (clr_ovf)
                r_ovf_q <= 1'b0;
        end
    end

    assign valid       = (r_cnt_q != '0);
    assign data        = w_out[c_EW-1:2];
    assign parity_err  = w_out[1];
    assign len_err     = w_out[0];
    assign overflow    = r_ovf_q;
    assign timeout_err = r_tout_q;
    assign busy        = (r_bits_q != 6'd0) || (r_state_q == ST_STOP);

endmodule
`default_nettype wire
